data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
Parametrised data memory for the MIPS32 datapath, the successor to the fixed 32-word, word/halfword-only store.
- Supports byte, halfword and word loads and stores, with sign or zero extension on load.
- Uses synchronous pipelined reads with a configurable read latency and a valid strobe.
- Flags misaligned accesses.
- Runs a hardware clear sweep after reset.
Sits between the MEM stage and the load writeback mux.

Parameters:
AW, 8, log2 of depth in 32-bit words (depth = 2^AW).
RD_LAT, 1, read latency in cycles from accept to Dvalid; legal values 1 or 2.
INIT_CLEAR, 1, 1 = zero every word after reset before accepting requests; 0 = skip the sweep.

Ports:
Clk  in  1  clock, rising edge.
Rst_n  in  1  asynchronous active-low reset.
Req  in  1  access request.
We  in  1  1 = store, 0 = load; sampled with Req.
Size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = illegal.
Uns  in  1  load zero-extend when 1, sign-extend when 0.
Addr  in  32  byte address; bits [AW+1:2] select the word, higher bits ignored (wrap).
Din  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
Ready  out  1  block can accept a request this cycle.
Busy  out  1  clear sweep in progress.
Dout  out  32  load result, extended to 32 bits.
Dvalid  out  1  Dout valid, one-cycle pulse per accepted load.
Misalign  out  1  error pulse for a bad access, aligned to the response slot.

Behaviour:
- Reset (async, Rst_n=0):
  - Ready=0, Busy=0, Dvalid=0, Misalign=0, Dout=0.
  - Pipeline valid bits cleared; FSM forced to INIT.
- FSM states: INIT, CLEAR, RUN.
  - INIT: first Clk edge after Rst_n rises → CLEAR if INIT_CLEAR=1, else RUN.
  - CLEAR: Busy=1, Ready=0. A counter 0..2^AW-1 writes 0 to one word per cycle; after the last word → RUN. The sweep takes exactly 2^AW cycles.
  - RUN: Busy=0, Ready=1.
- Accept rule: a request is accepted when Req && Ready at a rising edge. Req while Ready=0 is ignored and not queued. One access per cycle, fully pipelined.
- Byte lanes are little-endian: lane k = Addr[1:0]=k = bits [8k+7:8k].
- Alignment:
  - Halfword requires Addr[0]=0.
  - Word requires Addr[1:0]=0.
  - Size=3 is always illegal.
- Store (legal):
  - Byte enables are formed from Size and Addr[1:0].
  - Din is replicated into the lanes; only enabled lanes update, at the accept edge.
  - No Dvalid is produced.
- Load (legal):
  - Array read at the accept edge.
  - The selected lane is extracted and extended per Uns.
  - Dout and Dvalid are presented RD_LAT cycles after accept (RD_LAT=2 adds one output register stage).
  - Dout holds its last value when Dvalid=0.
- Illegal access (misaligned or Size=3):
  - Memory is not modified.
  - Misalign pulses RD_LAT cycles after accept, for loads and stores alike.
  - Loads also pulse Dvalid with Dout=0.
- Hazards:
  - A load accepted the cycle after a store to the same word returns the post-store data.
  - Back-to-back loads return in order, one per cycle.
- Reset mid-operation: in-flight loads are dropped, with no Dvalid. Memory contents are undefined until the sweep ends (INIT_CLEAR=1) or are retained (INIT_CLEAR=0). A sweep interrupted by reset restarts from word 0.
- Address wrap: Addr bits above AW+1 are ignored, so word 2^AW aliases word 0.

Decomposition:
- Shared package dmem_pkg holds:
  - size constants SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - FSM state encodings ST_INIT, ST_CLEAR, ST_RUN;
  - function for byte-enable generation.
- One combinational sub-module, dmem_rd_align: given word, Addr[1:0], Size and Uns, it returns the extended load value. It is instantiated in the read pipeline.

Test Plan:
1. AW=4, INIT_CLEAR=1: release Rst_n → Busy=1 and Ready=0 for exactly 16 cycles, then Ready=1. A load of every word returns 0x00000000.
2. Store word 0x8899AABB at 0x10, then load byte at 0x11 with Uns=0 → 0xFFFFFFAA. Load the same byte with Uns=1 → 0x000000AA. Load half at 0x12, Uns=0 → 0xFFFF8899. Each result arrives with Dvalid exactly RD_LAT cycles after accept (check RD_LAT=1 and 2).
3. Store byte 0x5A at 0x13 over word 0x11223344 at 0x10, next-cycle load word 0x10 → 0x5A223344.
4. Load half at 0x21 and store word at 0x22 → Misalign pulses at accept+RD_LAT each. The load returns Dvalid with Dout=0. Word 0x20 is unchanged.
5. Issue 4 back-to-back loads at addresses 0x00, 0x04, 0x08, 0x0C → 4 consecutive Dvalid pulses, in order, with the correct data.
6. Assert Rst_n=0 mid-sweep and with 2 loads in flight → Dvalid never pulses for them. The sweep restarts and Busy lasts the full 2^AW cycles again. With AW=4, INIT_CLEAR=0, Ready=1 one edge after release and prior contents are retained.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module : dmem_pkg
// Shared size codes, FSM states and lane helpers for the data memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    function automatic logic access_ok(input logic [1:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~off[0];
            SZ_WORD: ok = (off == 2'd0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-justified store data copied into every lane it could land in.
    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] din);
        logic [31:0] d;
        case (size)
            SZ_BYTE: d = {4{din[7:0]}};
            SZ_HALF: d = {2{din[15:0]}};
            default: d = din;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_rd_align.sv
// ============================================================================
// Module : dmem_rd_align
// Extracts the addressed byte/halfword of a read word and sign/zero extends it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dmem_rd_align
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        data   = 32'h0000_0000;
        case (off)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
        w_half = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: data = {{24{~uns & w_byte[7]}}, w_byte};
            SZ_HALF: data = {{16{~uns & w_half[15]}}, w_half};
            SZ_WORD: data = word;
            default: data = 32'h0000_0000;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module : data_mem_ctrl
// Byte/half/word data memory with post-reset clear sweep and pipelined reads.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int AW         = 8,
    parameter int RD_LAT     = 1,
    parameter int INIT_CLEAR = 1
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic        ready,
    output logic        busy,
    output logic [31:0] dout,
    output logic        dvalid,
    output logic        misalign
);

    localparam int DEPTH = 1 << AW;

    state_t         r_state;
    state_t         w_state_nx;
    logic [AW-1:0]  r_clr_cnt;
    logic [31:0]    r_mem [DEPTH];

    logic           w_acc;
    logic [AW-1:0]  w_idx;
    logic [1:0]     w_off;
    logic           w_ok;
    logic [3:0]     w_be;
    logic [31:0]    w_wdata;
    logic [31:0]    w_rd_word;
    logic [31:0]    w_ext;
    logic           w_unused_addr;

    logic           r_a_valid;
    logic           r_a_err;
    logic [31:0]    r_a_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end else begin
                r_clr_cnt <= '0;
            end
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_INIT:  w_state_nx = (INIT_CLEAR != 0) ? ST_CLEAR : ST_RUN;
            ST_CLEAR: if (&r_clr_cnt) w_state_nx = ST_RUN;
            ST_RUN:   w_state_nx = ST_RUN;
            default:  w_state_nx = ST_INIT;
        endcase
    end

    assign ready = (r_state == ST_RUN);
    assign busy  = (r_state == ST_CLEAR);

    assign w_acc         = req & ready;
    assign w_idx         = addr[AW+1:2];
    assign w_off         = addr[1:0];
    assign w_ok          = access_ok(size, w_off);
    assign w_be          = byte_en(size, w_off);
    assign w_wdata       = lane_rep(size, din);
    assign w_unused_addr = ^addr[31:AW+2];

    // Storage has no reset: contents survive reset unless the sweep clears them.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_cnt] <= 32'h0000_0000;
        end else if (w_acc && we && w_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
                end
            end
        end
    end

    assign w_rd_word = r_mem[w_idx];

    dmem_rd_align u_rd_align (
        .word (w_rd_word),
        .off  (w_off),
        .size (size),
        .uns  (uns),
        .data (w_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_valid <= 1'b0;
            r_a_err   <= 1'b0;
            r_a_data  <= 32'h0000_0000;
        end else begin
            r_a_valid <= w_acc & ~we;
            r_a_err   <= w_acc & ~w_ok;
            if (w_acc && !we) begin
                r_a_data <= w_ok ? w_ext : 32'h0000_0000;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic        r_b_valid;
            logic        r_b_err;
            logic [31:0] r_b_data;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_b_valid <= 1'b0;
                    r_b_err   <= 1'b0;
                    r_b_data  <= 32'h0000_0000;
                end else begin
                    r_b_valid <= r_a_valid;
                    r_b_err   <= r_a_err;
                    if (r_a_valid) begin
                        r_b_data <= r_a_data;
                    end
                end
            end

            assign dvalid   = r_b_valid;
            assign misalign = r_b_err;
            assign dout     = r_b_data;
        end else begin : g_lat1
            assign dvalid   = r_a_valid;
            assign misalign = r_a_err;
            assign dout     = r_a_data;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module : tb_data_mem_ctrl
// Directed bench driving three configurations of data_mem_ctrl in lockstep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [1:0]  size  = 2'd0;
    logic        uns   = 1'b0;
    logic [31:0] addr  = 32'h0;
    logic [31:0] din   = 32'h0;

    // d1: RD_LAT=1 with clear, d2: RD_LAT=2 with clear, d3: RD_LAT=1 no clear
    logic        ready1, busy1, dvalid1, mis1;
    logic        ready2, busy2, dvalid2, mis2;
    logic        ready3, busy3, dvalid3, mis3;
    logic [31:0] dout1, dout2, dout3;

    int          total = 0;
    int          bad   = 0;
    int          n;
    logic [31:0] bexp [16];

    always #5 clk = ~clk;

    data_mem_ctrl #(.AW(4), .RD_LAT(1), .INIT_CLEAR(1)) d1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .din(din), .ready(ready1), .busy(busy1), .dout(dout1),
        .dvalid(dvalid1), .misalign(mis1));

    data_mem_ctrl #(.AW(4), .RD_LAT(2), .INIT_CLEAR(1)) d2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .din(din), .ready(ready2), .busy(busy2), .dout(dout2),
        .dvalid(dvalid2), .misalign(mis2));

    data_mem_ctrl #(.AW(4), .RD_LAT(1), .INIT_CLEAR(0)) d3 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .din(din), .ready(ready3), .busy(busy3), .dout(dout3),
        .dvalid(dvalid3), .misalign(mis3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; size = sz; din = d; uns = 1'b0;
        tick();
        req = 1'b0; we = 1'b0;
    endtask

    // Single load; checks d1/d3 one cycle after accept and d2 two cycles after.
    task automatic load1(input logic [31:0] a, input logic [1:0] sz, input logic u,
                         input logic [31:0] exp, input logic err, input logic c3);
        req = 1'b1; we = 1'b0; addr = a; size = sz; uns = u;
        tick();
        req = 1'b0;
        chkb("d1_dvalid", dvalid1, 1'b1);
        chk ("d1_dout", dout1, exp);
        chkb("d1_misalign", mis1, err);
        chkb("d2_dvalid_early", dvalid2, 1'b0);
        if (c3) begin
            chkb("d3_dvalid", dvalid3, 1'b1);
            chk ("d3_dout", dout3, exp);
        end
        tick();
        chkb("d1_dvalid_end", dvalid1, 1'b0);
        chkb("d2_dvalid", dvalid2, 1'b1);
        chk ("d2_dout", dout2, exp);
        chkb("d2_misalign", mis2, err);
    endtask

    task automatic burst(input int cnt, input logic [31:0] base, input logic c3);
        for (int i = 0; i < cnt + 2; i++) begin
            if (i < cnt) begin
                req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0;
                addr = base + 32'(i * 4);
            end else begin
                req = 1'b0;
            end
            tick();
            if (i < cnt) begin
                chkb("burst_d1_dvalid", dvalid1, 1'b1);
                chk ("burst_d1_dout", dout1, bexp[i]);
                if (c3) chk("burst_d3_dout", dout3, bexp[i]);
            end else if (i == cnt) begin
                chkb("burst_d1_end", dvalid1, 1'b0);
            end
            if (i == 0) begin
                chkb("burst_d2_early", dvalid2, 1'b0);
            end else if (i <= cnt) begin
                chkb("burst_d2_dvalid", dvalid2, 1'b1);
                chk ("burst_d2_dout", dout2, bexp[i-1]);
            end else begin
                chkb("burst_d2_end", dvalid2, 1'b0);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2 rst_n = 1'b0;
        tick();
        tick();
        chkb("rst_ready1", ready1, 1'b0);
        chkb("rst_busy1", busy1, 1'b0);
        chkb("rst_dvalid1", dvalid1, 1'b0);
        chkb("rst_mis1", mis1, 1'b0);
        chk ("rst_dout1", dout1, 32'h0);
        chkb("rst_ready2", ready2, 1'b0);
        chk ("rst_dout2", dout2, 32'h0);
        chkb("rst_ready3", ready3, 1'b0);
        chkb("rst_busy3", busy3, 1'b0);

        // Clear sweep length
        rst_n = 1'b1;
        tick();
        chkb("sweep_busy1", busy1, 1'b1);
        chkb("sweep_ready1", ready1, 1'b0);
        chkb("sweep_busy2", busy2, 1'b1);
        chkb("noclear_ready3", ready3, 1'b1);
        chkb("noclear_busy3", busy3, 1'b0);
        n = 0;
        while (busy1 && n < 40) begin
            n++;
            tick();
        end
        chk ("sweep_len", 32'(n), 32'd16);
        chkb("post_sweep_ready1", ready1, 1'b1);
        chkb("post_sweep_ready2", ready2, 1'b1);
        chkb("post_sweep_busy2", busy2, 1'b0);

        // Every word reads zero after the sweep
        for (int i = 0; i < 16; i++) bexp[i] = 32'h0;
        burst(16, 32'h0, 1'b0);

        // Sub-word loads with extension
        store(32'h10, 2'd2, 32'h8899AABB);
        load1(32'h11, 2'd0, 1'b0, 32'hFFFFFFAA, 1'b0, 1'b1);
        load1(32'h11, 2'd0, 1'b1, 32'h000000AA, 1'b0, 1'b1);
        load1(32'h12, 2'd1, 1'b0, 32'hFFFF8899, 1'b0, 1'b1);
        load1(32'h12, 2'd1, 1'b1, 32'h00008899, 1'b0, 1'b1);
        load1(32'h13, 2'd0, 1'b0, 32'hFFFFFF88, 1'b0, 1'b1);

        // Byte store then immediate load of the same word, plus address wrap
        store(32'h10, 2'd2, 32'h11223344);
        store(32'h13, 2'd0, 32'h0000005A);
        load1(32'h10, 2'd2, 1'b0, 32'h5A223344, 1'b0, 1'b1);
        load1(32'h50, 2'd2, 1'b0, 32'h5A223344, 1'b0, 1'b1);
        store(32'h18, 2'd2, 32'h0);
        store(32'h1A, 2'd1, 32'h0000CAFE);
        load1(32'h18, 2'd2, 1'b0, 32'hCAFE0000, 1'b0, 1'b1);

        // Illegal accesses
        store(32'h20, 2'd2, 32'h01020304);
        load1(32'h21, 2'd1, 1'b0, 32'h0, 1'b1, 1'b1);
        req = 1'b1; we = 1'b1; addr = 32'h22; size = 2'd2; din = 32'hFFFFFFFF;
        tick();
        req = 1'b0; we = 1'b0;
        chkb("st_mis1", mis1, 1'b1);
        chkb("st_dvalid1", dvalid1, 1'b0);
        chkb("st_mis3", mis3, 1'b1);
        chkb("st_mis2_early", mis2, 1'b0);
        tick();
        chkb("st_mis1_end", mis1, 1'b0);
        chkb("st_mis2", mis2, 1'b1);
        chkb("st_dvalid2", dvalid2, 1'b0);
        load1(32'h20, 2'd2, 1'b0, 32'h01020304, 1'b0, 1'b1);
        load1(32'h20, 2'd3, 1'b0, 32'h0, 1'b1, 1'b1);

        // Back-to-back loads in order
        store(32'h00, 2'd2, 32'hDEADBEEF);
        store(32'h04, 2'd2, 32'h00000001);
        store(32'h08, 2'd2, 32'h80000000);
        store(32'h0C, 2'd2, 32'h12345678);
        bexp[0] = 32'hDEADBEEF;
        bexp[1] = 32'h00000001;
        bexp[2] = 32'h80000000;
        bexp[3] = 32'h12345678;
        burst(4, 32'h0, 1'b1);

        // Reset with loads in flight
        req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h00;
        tick();
        addr = 32'h04;
        tick();
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        chkb("inflight_dvalid1", dvalid1, 1'b0);
        chkb("inflight_dvalid2", dvalid2, 1'b0);
        chk ("inflight_dout2", dout2, 32'h0);
        tick();
        chkb("inflight_dvalid2_late", dvalid2, 1'b0);
        rst_n = 1'b1;
        tick();
        chkb("rerun_ready3", ready3, 1'b1);
        chkb("rerun_busy1", busy1, 1'b1);
        // Load while d1/d2 sweep: only d3 answers, with retained contents
        req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h10;
        tick();
        req = 1'b0;
        chkb("retain_dvalid3", dvalid3, 1'b1);
        chk ("retain_dout3", dout3, 32'h5A223344);
        chkb("ignored_dvalid1", dvalid1, 1'b0);
        tick();
        chkb("ignored_dvalid2", dvalid2, 1'b0);

        // Interrupt the sweep and confirm it restarts in full
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chkb("midsweep_busy1", busy1, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        n = 0;
        while (busy1 && n < 40) begin
            n++;
            tick();
        end
        chk ("resweep_len", 32'(n), 32'd16);
        load1(32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
